// File: rtl/aes_dec_controller.sv
// Sequencing FSM for the AES-128 decryption datapath.
// The FSM first runs the forward key expansion up to rk[NR]. It then walks
// the inverse rounds from NR down to 0 while stepping the key schedule
// backwards. The result is held as done until the host acknowledges it.
module aes_dec_controller #(
  parameter int NR = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       ack_i,
  output logic       load_o,
  output logic       key_exp_o,
  output logic       key_inv_o,
  output logic       sel_init_o,
  output logic       sel_round_o,
  output logic       sel_last_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_KEYEXP = 3'd2;
  localparam logic [2:0] S_INIT   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_LAST   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] NR_C  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State and round counter; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = 4'd0;
        state_d = S_KEYEXP;
      end
      S_KEYEXP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NR_M1) state_d = S_INIT;
      end
      S_INIT: begin
        // With a single round there are no full inverse rounds to run.
        cnt_d   = NR_M1;
        state_d = (NR_M1 == 4'd0) ? S_LAST : S_ROUND;
      end
      S_ROUND: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_LAST;
      end
      S_LAST: begin
        cnt_d   = 4'd0;
        state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d = 4'd0;
        if (ack_i) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from state and counter.
  always_comb begin
    load_o      = 1'b0;
    key_exp_o   = 1'b0;
    key_inv_o   = 1'b0;
    sel_init_o  = 1'b0;
    sel_round_o = 1'b0;
    sel_last_o  = 1'b0;
    round_o     = 4'd0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_o = 1'b1;
        busy_o = 1'b1;
      end
      S_KEYEXP: begin
        key_exp_o = 1'b1;
        busy_o    = 1'b1;
        round_o   = cnt_q + 4'd1;
      end
      S_INIT: begin
        sel_init_o = 1'b1;
        key_inv_o  = 1'b1;
        busy_o     = 1'b1;
        round_o    = NR_C;
      end
      S_ROUND: begin
        sel_round_o = 1'b1;
        key_inv_o   = 1'b1;
        busy_o      = 1'b1;
        round_o     = cnt_q;
      end
      S_LAST: begin
        sel_last_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_controller.sv
// Bench for aes_dec_controller. It runs an NR=10 and an NR=12 instance side
// by side. Both are compared each cycle against a timeline reference model.
module tb_aes_dec_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start, ack;

  always #5 clk = ~clk;

  logic       a_load, a_kexp, a_kinv, a_init, a_rnd, a_last, a_busy, a_done;
  logic [3:0] a_round;
  logic       b_load, b_kexp, b_kinv, b_init, b_rnd, b_last, b_busy, b_done;
  logic [3:0] b_round;

  aes_dec_controller #(.NR(10)) u_dut10 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ack_i(ack),
    .load_o(a_load), .key_exp_o(a_kexp), .key_inv_o(a_kinv),
    .sel_init_o(a_init), .sel_round_o(a_rnd), .sel_last_o(a_last),
    .round_o(a_round), .busy_o(a_busy), .done_o(a_done)
  );

  aes_dec_controller #(.NR(12)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ack_i(ack),
    .load_o(b_load), .key_exp_o(b_kexp), .key_inv_o(b_kinv),
    .sel_init_o(b_init), .sel_round_o(b_rnd), .sel_last_o(b_last),
    .round_o(b_round), .busy_o(b_busy), .done_o(b_done)
  );

  int nvec = 0;
  int nerr = 0;
  int t10  = 0;   // cycles since start was accepted; 0 = idle
  int t12  = 0;
  int kinv10 = 0, kinv12 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {load,kexp,kinv,init,round_sel,last,busy,done,round[3:0]}
  // at cycle t of a decryption with nr rounds.
  function automatic logic [11:0] exp_vec(input int nr, input int t);
    logic [7:0] f;
    int r;
    f = 8'b0;
    r = 0;
    if (t == 1)                           f = 8'b1000_0010;
    else if (t >= 2 && t <= nr + 1)      begin f = 8'b0100_0010; r = t - 1; end
    else if (t == nr + 2)                begin f = 8'b0011_0010; r = nr; end
    else if (t >= nr + 3 && t <= 2*nr+1) begin f = 8'b0010_1010; r = 2*nr + 2 - t; end
    else if (t == 2*nr + 2)              f = 8'b0000_0110;
    else if (t == 2*nr + 3)              f = 8'b0000_0001;
    return {f, 4'(r)};
  endfunction

  function automatic int next_t(input int nr, input int t, input logic s, input logic a);
    if (t == 0)          return s ? 1 : 0;
    if (t < 2*nr + 3)    return t + 1;
    return a ? 0 : t;
  endfunction

  function automatic logic [11:0] vec10();
    return {a_load, a_kexp, a_kinv, a_init, a_rnd, a_last, a_busy, a_done, a_round};
  endfunction

  function automatic logic [11:0] vec12();
    return {b_load, b_kexp, b_kinv, b_init, b_rnd, b_last, b_busy, b_done, b_round};
  endfunction

  task automatic check_all();
    logic [11:0] v10, v12;
    v10 = vec10();
    v12 = vec12();
    chk("outputs_nr10", 32'(v10), 32'(exp_vec(10, t10)));
    chk("outputs_nr12", 32'(v12), 32'(exp_vec(12, t12)));
    chk("mutex_nr10", 32'($countones({v10[11], v10[10], v10[8], v10[7], v10[6]}) <= 1), 32'd1);
    chk("mutex_nr12", 32'($countones({v12[11], v12[10], v12[8], v12[7], v12[6]}) <= 1), 32'd1);
    kinv10 += int'(a_kinv);
    kinv12 += int'(b_kinv);
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      t10 = 0;
      t12 = 0;
    end else begin
      t10 = next_t(10, t10, start, ack);
      t12 = next_t(12, t12, start, ack);
    end
    @(negedge clk);
    check_all();
  endtask

  int lat10, lat12;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    #2;
    chk("reset_nr10", 32'(vec10()), 32'd0);
    chk("reset_nr12", 32'(vec12()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full run with a stray start pulse during key expansion and a long wait in DONE.
    kinv10 = 0;
    kinv12 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      start = (i == 4);
      step();
    end
    start = 1'b0;
    chk("kinv_count_nr10", 32'(kinv10), 32'd10);
    chk("kinv_count_nr12", 32'(kinv12), 32'd12);
    chk("done_held_nr10", 32'(a_done), 32'd1);

    // Acknowledge together with start: start must be ignored.
    ack = 1'b1;
    start = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    chk("idle_after_ack_nr10", 32'(a_done | a_busy | a_load), 32'd0);
    step();

    // Asynchronous reset in the middle of the inverse rounds (round 5 for NR=10).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && t10 != 17; i++) step();
    chk("round5_reached", 32'(a_round), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    t10 = 0;
    t12 = 0;
    chk("async_reset_nr10", 32'(vec10()), 32'd0);
    chk("async_reset_nr12", 32'(vec12()), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Clean run after reset, measuring latency to done.
    lat10 = 0;
    lat12 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (a_done && lat10 == 0) lat10 = n;
      if (b_done && lat12 == 0) lat12 = n;
      if (lat10 != 0 && lat12 != 0) break;
      step();
    end
    chk("latency_nr10", 32'(lat10), 32'd23);
    chk("latency_nr12", 32'(lat12), 32'd27);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    // Randomized start/ack traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 7) == 0);
      step();
    end
    start = 1'b0;
    ack   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
